// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a small in-order queue.
// Head outputs come only from registered queue entries, so a response reaches decode one cycle later.
module fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter int          QDEPTH    = 2,
  parameter logic [15:0] NOP_INSTR = 16'hE000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        flush,
  input  logic [7:0]  redirect_pc,
  input  logic        decode_ready,
  output logic        instr_valid,
  output logic [15:0] instruction,
  output logic [7:0]  instr_pc
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t state, state_nx;
  logic [7:0] pc, req_pc;
  logic [15:0] q_data [QDEPTH];
  logic [7:0] q_pc [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // issuing only below full is what makes queue overflow impossible
  assign imem_req    = reset && state == IDLE && !flush && count < CW'(QDEPTH);
  assign imem_addr   = pc;
  assign instr_valid = count != '0;
  assign instruction = instr_valid ? q_data[head] : NOP_INSTR;
  assign instr_pc    = instr_valid ? q_pc[head] : 8'h00;
  assign push        = state == WAIT && imem_rvalid && !flush;
  assign pop         = instr_valid && decode_ready && !flush;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = imem_req ? WAIT : IDLE;
      WAIT:    state_nx = imem_rvalid ? IDLE : flush ? DISCARD : WAIT;
      DISCARD: state_nx = imem_rvalid ? IDLE : DISCARD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= 8'h00;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      pc    <= flush ? redirect_pc : imem_req ? pc + 8'd1 : pc;
      if (imem_req) req_pc <= pc;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= inc(tail);
        if (pop) head <= inc(head);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= imem_rdata;
      q_pc[tail]   <= req_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios; every cycle is compared against a queue-level model,
// and each scenario's issued addresses and consumed instructions are pinned to literal values.
module tb_fetch_unit;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam int          QD       = 2;
  localparam logic [15:0] NOP      = 16'hE000;

  logic clk = 0, reset = 0, imem_req, imem_rvalid = 0, flush = 0, decode_ready = 0, instr_valid;
  logic [7:0] imem_addr, instr_pc, redirect_pc = 8'h00;
  logic [15:0] imem_rdata = 16'h0000, instruction;
  int n_checks = 0, n_err = 0;

  logic [15:0] mem [256];
  int lat = 1, pcnt = 0;
  bit pend = 0;
  logic [7:0] paddr = 8'h00;

  logic [23:0] m_q [$];
  logic [23:0] head_e;
  bit m_out = 0, m_keep = 0;
  logic [7:0] m_pc = RESET_PC, m_addr = 8'h00;
  logic e_req, e_valid;
  logic [15:0] e_instr;
  logic [7:0] e_pc;
  logic [7:0] reqs [$];
  logic [23:0] pops [$];

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QD), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
    .redirect_pc(redirect_pc), .decode_ready(decode_ready), .instr_valid(instr_valid),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return i < reqs.size() ? 32'(reqs[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return i < pops.size() ? 32'(pops[i]) : 32'hFFFF_FFFF;
  endfunction

  // model: a queue of {data,pc}, one outstanding-request flag and whether its answer is wanted
  always @(negedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_out = 0;
      m_pc = RESET_PC;
      e_req = 0;
      e_valid = 0;
      e_instr = NOP;
      e_pc = 8'h00;
    end else begin
      head_e = m_q.size() > 0 ? m_q[0] : 24'h0;
      e_valid = m_q.size() > 0;
      e_instr = e_valid ? head_e[23:8] : NOP;
      e_pc = e_valid ? head_e[7:0] : 8'h00;
      e_req = !m_out && !flush && m_q.size() < QD;
    end
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("instruction", 32'(instruction), 32'(e_instr));
    chk("instr_pc", 32'(instr_pc), 32'(e_pc));
    if (reset) begin
      if (imem_req) reqs.push_back(imem_addr);
      if (instr_valid && decode_ready && !flush) pops.push_back({instruction, instr_pc});
      if (flush) begin
        m_q.delete();
        m_pc = redirect_pc;
        if (m_out && imem_rvalid) m_out = 0;
        else m_keep = 0;
      end else begin
        if (e_valid && decode_ready) void'(m_q.pop_front());
        if (m_out && imem_rvalid) begin
          if (m_keep) m_q.push_back({imem_rdata, m_addr});
          m_out = 0;
        end
        if (e_req) begin
          m_out = 1;
          m_keep = 1;
          m_addr = m_pc;
          m_pc = m_pc + 8'd1;
        end
      end
    end
  end

  // one clock: memory responder drives rvalid, then captures any request seen mid-cycle
  task automatic step();
    if (pend && pcnt <= 1) begin
      imem_rvalid = 1;
      imem_rdata = mem[paddr];
      pend = 0;
    end else begin
      imem_rvalid = 0;
      imem_rdata = 16'hDEAD;
      if (pend) pcnt--;
    end
    @(negedge clk);
    #1;
    if (imem_req) begin
      pend = 1;
      pcnt = lat;
      paddr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    flush = 0;
    pend = 0;
    repeat (2) step();
    reset = 1;
    reqs.delete();
    pops.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      mem[i] = {b, ~b};
    end
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[2] = 16'h9ABC;
    mem[8'h40] = 16'h4040;

    // reset with a stray response during reset, then latency-1 streaming
    reset = 0;
    pend = 1;
    pcnt = 1;
    paddr = 8'h05;
    decode_ready = 1;
    repeat (2) step();
    reset = 1;
    reqs.delete();
    pops.delete();
    repeat (7) step();
    chk("s1 req count", reqs.size(), 4);
    chk("s1 req0", req_at(0), 32'h00);
    chk("s1 req1", req_at(1), 32'h01);
    chk("s1 req2", req_at(2), 32'h02);
    chk("s1 pop count", pops.size(), 3);
    chk("s1 pop0", pop_at(0), 32'h123400);
    chk("s1 pop1", pop_at(1), 32'h567801);
    chk("s1 pop2", pop_at(2), 32'h9ABC02);

    // backpressure: queue fills to depth, head holds, then drains in order
    do_reset();
    decode_ready = 0;
    repeat (10) step();
    chk("s2 req count", reqs.size(), QD);
    chk("s2 head instr", 32'(instruction), 32'h1234);
    chk("s2 head pc", 32'(instr_pc), 32'h00);
    decode_ready = 1;
    repeat (4) step();
    chk("s2 pop0", pop_at(0), 32'h123400);
    chk("s2 pop1", pop_at(1), 32'h567801);
    chk("s2 pop2", pop_at(2), 32'h9ABC02);

    // flush while a request to 20 is outstanding; its response comes 2 cycles later
    do_reset();
    lat = 3;
    flush = 1;
    redirect_pc = 8'h20;
    step();
    flush = 0;
    step();
    flush = 1;
    redirect_pc = 8'h40;
    step();
    flush = 0;
    repeat (2) step();
    chk("s3 valid after drop", 32'(instr_valid), 32'h0);
    chk("s3 nop after drop", 32'(instruction), 32'hE000);
    repeat (5) step();
    chk("s3 req0", req_at(0), 32'h20);
    chk("s3 req1", req_at(1), 32'h40);
    chk("s3 pop count", pops.size(), 1);
    chk("s3 pop0", pop_at(0), 32'h404040);

    // flush coinciding with rvalid, then back-to-back flushes where the last target wins
    do_reset();
    lat = 1;
    step();
    flush = 1;
    redirect_pc = 8'h50;
    step();
    chk("s4 valid after drop", 32'(instr_valid), 32'h0);
    flush = 0;
    step();
    flush = 1;
    redirect_pc = 8'h60;
    step();
    redirect_pc = 8'h70;
    step();
    flush = 0;
    repeat (3) step();
    chk("s4 req0", req_at(0), 32'h00);
    chk("s4 req1", req_at(1), 32'h50);
    chk("s4 req2", req_at(2), 32'h70);
    chk("s4 pop count", pops.size(), 1);
    chk("s4 pop0", pop_at(0), 32'h708F70);

    // pc wraps from FF to 00
    do_reset();
    flush = 1;
    redirect_pc = 8'hFF;
    step();
    flush = 0;
    repeat (5) step();
    chk("s5 req0", req_at(0), 32'hFF);
    chk("s5 req1", req_at(1), 32'h00);
    chk("s5 pop0", pop_at(0), 32'hFF00FF);
    chk("s5 pop1", pop_at(1), 32'h123400);

    // reset while waiting; the late response lands after release and is ignored
    do_reset();
    lat = 3;
    step();
    reset = 0;
    repeat (2) step();
    reset = 1;
    reqs.delete();
    pops.delete();
    step();
    chk("s6 valid after stale", 32'(instr_valid), 32'h0);
    chk("s6 first req", req_at(0), 32'(RESET_PC));
    repeat (4) step();
    chk("s6 pop count", pops.size(), 1);
    chk("s6 pop0", pop_at(0), 32'h123400);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RESET_PC, 8'h00, PC loaded at reset.
- QDEPTH, 2, instruction queue depth in entries (>=2).
- NOP_INSTR, 16'hE000, instruction presented when no valid entry is available.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction-memory read request; valid for one cycle per request.
- imem_addr  out  8  word address of the request.
- imem_rvalid  in  1  read data valid; arrives 1 or more cycles after imem_req.
- imem_rdata  in  16  read data.
- flush  in  1  discard all fetched or in-flight instructions and redirect.
- redirect_pc  in  8  new PC, sampled when flush=1.
- decode_ready  in  1  decode stage accepts the head instruction this cycle.
- instr_valid  out  1  queue head holds a valid instruction.
- instruction  out  16  queue head instruction, or NOP_INSTR when instr_valid=0.
- instr_pc  out  8  PC of the head instruction, or 8'h00 when instr_valid=0.

Function
REQ-003 Fetch FSM SHALL have three states:
- IDLE: no request outstanding.
- WAIT: one request outstanding; the response will be kept.
- DISCARD: one request outstanding; the response will be dropped.
REQ-004 imem_req SHALL be 1 exactly when: state=IDLE, flush=0, reset deasserted, and queue count < QDEPTH.
- imem_addr SHALL equal pc in that cycle.
REQ-005 On issue, pc SHALL increment by 1 modulo 256 (8'hFF -> 8'h00), and the FSM SHALL go IDLE -> WAIT.
REQ-006 At most one request SHALL be outstanding; no request SHALL issue in WAIT or DISCARD.
REQ-007 In WAIT with imem_rvalid=1 and flush=0:
- {imem_rdata, request address} SHALL be pushed to the queue tail.
- The FSM SHALL go to IDLE.
- A new request MAY issue in the following cycle.
REQ-008 In DISCARD with imem_rvalid=1, the data SHALL be dropped and the FSM SHALL go to IDLE.
REQ-009 imem_rvalid in IDLE SHALL be ignored.
REQ-010 A pop SHALL occur when instr_valid=1, decode_ready=1 and flush=0; the next entry becomes head on the following cycle.
REQ-011 Push and pop in the same cycle SHALL leave count unchanged.
REQ-012 Overflow SHALL be impossible by construction: issue requires count < QDEPTH.
REQ-013 Head outputs (instr_valid, instruction, instr_pc) SHALL be driven combinationally from registered queue storage; zero-latency pass-through from imem_rdata is not permitted.
- Minimum latency from imem_rvalid to instr_valid SHALL be 1 cycle.
REQ-014 On flush=1:
- The queue SHALL be emptied and pc <= redirect_pc.
- No pop and no request SHALL occur in that cycle.
- Next state SHALL be: WAIT -> DISCARD if imem_rvalid=0; WAIT -> IDLE if imem_rvalid=1 (data dropped); DISCARD -> DISCARD if imem_rvalid=0, else IDLE; IDLE -> IDLE.
REQ-015 After a flush, the first request SHALL use redirect_pc, issued in the first cycle in which the FSM is IDLE.
REQ-016 Consecutive flush cycles SHALL each reload pc; the last redirect_pc wins.
REQ-017 While decode_ready=0:
- Head outputs SHALL hold stable.
- Fetching SHALL continue until count reaches QDEPTH.

Reset
REQ-018 reset=0 SHALL asynchronously set: pc=RESET_PC, queue empty, FSM=IDLE.
- Outputs while reset=0: imem_req=0, instr_valid=0, instruction=NOP_INSTR, instr_pc=8'h00.
REQ-019 imem_rvalid during reset SHALL be ignored.
REQ-020 On the first clock after deassertion, a request to RESET_PC SHALL issue.
REQ-021 Asserting reset mid-request SHALL return the FSM to IDLE; the late response, if it arrives after deassertion, SHALL be ignored per REQ-009.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset release, memory latency 1, decode_ready=1, mem[0..2]=16'h1234/16'h5678/16'h9ABC -> imem_addr 00,01,02 in order; instruction 1234@pc00, 5678@pc01, 9ABC@pc02 each appear once; no gaps beyond one cycle per fetch.
- decode_ready=0 for 10 cycles -> exactly QDEPTH requests issued, then imem_req=0; head stays 1234/pc00; on release, entries drain in order.
- Request to 8'h20 outstanding, flush=1 with redirect_pc=8'h40, response arrives 2 cycles later -> response dropped; instr_valid=0 and instruction=16'hE000 until mem[40] returns; next imem_addr=8'h40.
- flush in the same cycle as imem_rvalid -> data dropped; FSM IDLE; request at redirect_pc on the next cycle.
- pc=8'hFF -> requests to FF then 00; instr_pc sequence FF,00.
- reset asserted while WAIT, response arrives after deassertion -> queue stays empty; first new request at RESET_PC.
